// File: rtl/map_pkg.sv
// Shared definitions for the feature-map blocks: default sizes, the
// streaming FSM state encoding and the ceiling-log2 used to size counters.
package map_pkg;

    localparam int MAP_DATA_WIDTH = 16;
    localparam int MAP_SIZE       = 65536;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Ceiling log2; clog2_f(1) = 0, clog2_f(5) = 3, clog2_f(257) = 9.
    function automatic int clog2_f(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/map_elem_select.sv
// Element selector: picks element sel_i out of a flat feature-map bus.
// Purely combinational so it can be pipelined or swapped without touching
// the streaming FSM.
module map_elem_select #(
    parameter int DATA_WIDTH = 16,
    parameter int SIZE       = 4,
    parameter int ADDR_W     = 3
) (
    input  logic [SIZE*DATA_WIDTH-1:0] all_i,
    input  logic [ADDR_W-1:0]          sel_i,
    output logic [DATA_WIDTH-1:0]      elem_o
);

    // Indexed part-select; indices past the map read as zero.
    always_comb begin
        elem_o = '0;
        if (int'(sel_i) < SIZE) begin
            elem_o = all_i[int'(sel_i)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/map_stream_out.sv
// Parallel-to-serial reader for a complete feature map. Emits element 0..SIZE-1
// of the flat all_in bus one per valid/ready handshake, then pulses done.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no map in flight; load starts a new map at element 0
// STREAM | data_out holds element idx_out, valid_out=1, waiting for ready
module map_stream_out
    import map_pkg::*;
#(
    parameter  int DATA_WIDTH = MAP_DATA_WIDTH,
    parameter  int SIZE       = MAP_SIZE,
    localparam int ADDR_W     = clog2_f(SIZE + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic [SIZE*DATA_WIDTH-1:0] all_in,
    input  logic                       flush,
    input  logic                       ready_in,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       valid_out,
    output logic [ADDR_W-1:0]          idx_out,
    output logic                       busy,
    output logic                       done
);

    // Index compares are done in ADDR_W bits, which can hold SIZE itself,
    // so a power-of-two SIZE never aliases back to index 0.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SIZE - 1);

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    done_q, done_d;
    logic [ADDR_W-1:0]       sel;
    logic [DATA_WIDTH-1:0]   elem;

    map_elem_select #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIZE       (SIZE),
        .ADDR_W     (ADDR_W)
    ) u_elem_select (
        .all_i  (all_in),
        .sel_i  (sel),
        .elem_o (elem)
    );

    // Look-ahead select: the element that data_out takes on the next accepted step.
    always_comb begin
        sel = '0;
        if (state_q == STREAM && idx_q != LAST_IDX) begin
            sel = idx_q + 1'b1;
        end
    end

    // Next-state logic; flush outranks both load and a transfer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        done_d  = 1'b0;
        if (flush) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_d = STREAM;
                        idx_d   = '0;
                        data_d  = elem;
                    end
                end
                STREAM: begin
                    if (ready_in) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = IDLE;
                            idx_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            idx_d  = idx_q + 1'b1;
                            data_d = elem;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign data_out  = data_q;
    assign idx_out   = idx_q;
    assign valid_out = (state_q == STREAM);
    assign busy      = (state_q == STREAM);
    assign done      = done_q;

endmodule

// File: doc/map_stream_out.md
Name: map_stream_out

Overview:
- Parallel-to-serial reader for a whole feature map: takes the flat SIZE*DATA_WIDTH bus produced by the map collection buffer and emits it one element per handshake.
- Sits between a full-map buffer (or any block presenting a complete flat map) and the next streaming stage (conv/pool input).
- Element i is all_in[i*DATA_WIDTH +: DATA_WIDTH], emitted in ascending index order 0..SIZE-1.

Parameters:
- DATA_WIDTH, 16, bits per element.
- SIZE, 65536 (256*256), elements per map; must be >= 1.
- ADDR_W, ceil(log2(SIZE+1)), derived local constant; width of the index counter, which must hold SIZE.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  start request; sampled only in IDLE.
- all_in  in  SIZE*DATA_WIDTH  flat map; must be held stable from the accepted load until done.
- flush  in  1  synchronous abort; returns to IDLE without a done pulse.
- ready_in  in  1  downstream ready.
- data_out  out  DATA_WIDTH  current element (registered).
- valid_out  out  1  data_out is valid.
- idx_out  out  ADDR_W  index of the element on data_out.
- busy  out  1  high in STREAM.
- done  out  1  one-cycle pulse after the last element transfers.

Behaviour:
- Reset (async): state=IDLE; data_out=0, valid_out=0, idx_out=0, busy=0, done=0.
- States: IDLE, STREAM.
- IDLE:
  - load=1 at edge k: state=STREAM, data_out=element 0, idx_out=0, valid_out=1, busy=1, all after edge k. Latency from load to first valid is 1 cycle.
  - done is 0 in IDLE, except for the single pulse cycle described under last transfer.
- STREAM:
  - A transfer occurs on an edge where valid_out && ready_in.
  - Transfer at idx<SIZE-1: idx_out+1, data_out=element idx+1, valid_out stays 1 (no bubble). Full rate is one element per cycle.
  - Transfer at idx=SIZE-1: valid_out=0, busy=0, idx_out=0, data_out holds its last value, done=1 for exactly one cycle, state=IDLE.
  - While valid_out && !ready_in: data_out, idx_out and valid_out hold unchanged (backpressure).
- load while in STREAM: ignored, no restart.
- load in the same cycle that done is high: accepted (state is IDLE). Back-to-back maps need one idle gap cycle at most.
- flush=1 in any state: next edge gives state=IDLE, valid_out=0, busy=0, idx_out=0, done=0. flush has priority over load and over a transfer in the same cycle.
- SIZE=1: load → one valid beat with element 0; its transfer → done pulse.
- Reset mid-stream: immediate return to the reset values; the partial map is discarded and the next load restarts at element 0.
- all_in changing during STREAM is an upstream protocol violation. Emitted data is undefined from that point; no detection is required.
- Width rules:
  - Index compares use ADDR_W bits, so there is no wrap at SIZE = 2^n.
  - Element select is an indexed part-select on all_in.
  - No arithmetic is performed on data.

Decomposition:
- Shared package map_pkg holds:
  - the log2/clog2 constant function (the same ceiling-log2 used by the collection buffer);
  - default DATA_WIDTH=16 and MAP_SIZE=65536;
  - state encoding IDLE=1'b0, STREAM=1'b1.
- Optional sub-module map_elem_select: purely combinational mux, flat bus + index → element. It is kept separate so synthesis and timing can pipeline or replace it independently of the FSM.
- Everything else lives in map_stream_out.

Test Plan:
- Bench runs with SIZE=4, DATA_WIDTH=16, all_in = {16'h0004,16'h0003,16'h0002,16'h0001}.
- Basic: ready_in=1, pulse load → valid_out high the next cycle; data_out=1,2,3,4 on consecutive cycles with idx_out 0..3; done=1 exactly the cycle after the 4th transfer; busy low afterwards.
- Backpressure: ready_in low for 3 cycles while idx_out=1 → data_out stays 0x0002 and valid_out stays 1; on release the sequence resumes with 2,3,4 and no element is duplicated or lost.
- Flush/load priority: flush asserted while idx_out=2 → IDLE, valid_out=0, no done. A load in the same cycle as flush is ignored. A fresh load then restarts at 0x0001.
- Async reset mid-stream: at idx_out=2 → all outputs 0 immediately, before the next clk edge. A later load streams 1..4 correctly.
- Load during STREAM at idx_out=1 → ignored, sequence unchanged, one done pulse. Load on the done cycle → element 0 valid the next cycle.
- SIZE=1 variant with all_in=16'hBEEF → one beat of 0xBEEF, then done. A SIZE=256 variant checks that idx_out reaches 255 and terminates without wrap.
